vga_dec_chars: RTL

Sequential binary-to-decimal formatter that feeds the `characters` bus of the VGA text-box renderer. It accepts a binary value on a start strobe and converts it iteratively with shift-and-add-3 (double dabble). It then emits a right-aligned, leading-blank, optionally signed string of 7-bit glyph codes. Output is held stable between conversions, so the renderer can sample it on any pixel cycle.

---
 rtl/vga_chars_pkg.sv | 22 ++
 rtl/vga_dec_chars_dd_digit.sv | 16 +
 rtl/vga_dec_chars.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vga_chars_pkg.sv
// Shared glyph codes and FSM encoding for the VGA text-box character producers.
// The text-box renderer imports the same glyph constants.
package vga_chars_pkg;

  localparam logic [6:0] CHR_SPACE  = 7'd0;
  localparam logic [6:0] CHR_BANG   = 7'd27;
  localparam logic [6:0] CHR_DIGIT0 = 7'd28;
  localparam logic [6:0] CHR_PLUS   = 7'd64;
  localparam logic [6:0] CHR_MINUS  = 7'd65;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_FORMAT  = 2'd2
  } state_e;

  // Number of BCD digits needed to hold any WIDTH-bit unsigned value.
  function automatic int dec_digits(input int width);
    return (width * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/vga_dec_chars_dd_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decade.
module dd_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/vga_dec_chars.sv
// Iterative binary-to-decimal formatter producing a right-aligned glyph string
// for the VGA text-box renderer; output only changes on the FORMAT edge or reset.
module vga_dec_chars
  import vga_chars_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SYMBOLS = 6,
  parameter int SIGNED  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     value,
  output logic                 busy,
  output logic                 valid,
  output logic [7*SYMBOLS-1:0] characters,
  output logic                 overflow
);

  localparam int DIGITS = dec_digits(WIDTH);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [7*SYMBOLS-1:0] chars_q, chars_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;

  logic                 value_neg;
  logic [7:0]           n_dig;
  logic [7:0]           w_req;
  logic                 fmt_ovf;
  logic [7*SYMBOLS-1:0] fmt_chars;

  genvar gi;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dd
      dd_digit u_dd (
        .din  (bcd_q[4*gi +: 4]),
        .dout (bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CONVERT;
      ST_CONVERT: if (cnt_q == '0) state_d = ST_FORMAT;
      ST_FORMAT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  assign valid      = valid_q;
  assign characters = chars_q;
  assign overflow   = ovf_q;

  assign value_neg = (SIGNED != 0) && value[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      chars_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      chars_q <= chars_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    chars_d = chars_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          neg_d = value_neg;
          mag_d = value_neg ? (~value + WIDTH'(1)) : value;
          bcd_d = '0;
          cnt_d = CNT_W'(WIDTH - 1);
        end
      end
      ST_CONVERT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FORMAT: begin
        chars_d = fmt_chars;
        ovf_d   = fmt_ovf;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Significant digit count: position of the highest non-zero digit, at least one.
  always_comb begin
    n_dig = 8'd1;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] != 4'd0) begin
        n_dig = 8'(d + 1);
      end
    end
  end

  assign w_req   = n_dig + {7'd0, neg_q};
  assign fmt_ovf = (w_req > 8'(SYMBOLS));

  // Slot gi shows digit P (counted from the right), the minus sign just left
  // of the leading digit, or a blank; slots beyond the BCD range never hold digits.
  generate
    for (gi = 0; gi < SYMBOLS; gi++) begin : g_slot
      localparam int P = SYMBOLS - 1 - gi;
      logic [6:0] slot;
      if (P < DIGITS) begin : g_dig
        always_comb begin
          if (fmt_ovf) begin
            slot = CHR_BANG;
          end else if (8'(P) < n_dig) begin
            slot = CHR_DIGIT0 + {3'd0, bcd_q[4*P +: 4]};
          end else if (neg_q && (8'(P) == n_dig)) begin
            slot = CHR_MINUS;
          end else begin
            slot = CHR_SPACE;
          end
        end
      end else begin : g_pad
        always_comb begin
          if (fmt_ovf) begin
            slot = CHR_BANG;
          end else if (neg_q && (8'(P) == n_dig)) begin
            slot = CHR_MINUS;
          end else begin
            slot = CHR_SPACE;
          end
        end
      end
      assign fmt_chars[7*gi +: 7] = slot;
    end
  endgenerate

endmodule
